// File: rtl/datapath_pkg.sv
// datapath_pkg: opcodes, FSM states and NZCV bit positions shared by the ALU datapath.
package datapath_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_ADDS = 4'b0010;
    localparam logic [3:0] OP_SUBS = 4'b0011;
    localparam logic [3:0] OP_CMP  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_ADC  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_ORR  = 4'b1000;
    localparam logic [3:0] OP_EOR  = 4'b1001;
    localparam logic [3:0] OP_MVN  = 4'b1010;
    localparam logic [3:0] OP_LSL  = 4'b1011;
    localparam logic [3:0] OP_LSR  = 4'b1100;
    localparam logic [3:0] OP_ASR  = 4'b1101;
    localparam logic [3:0] OP_MOV  = 4'b1110;
    localparam logic [3:0] OP_RSVD = 4'b1111;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/regfile_param.sv
// regfile_param: register file with two combinational reads and two prioritised synchronous writes.
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] waddr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] waddr1,
    input  logic [DATA_WIDTH-1:0] wdata1
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

    // port 0 is assigned last so it wins a same-address collision
    always_ff @(posedge clock) begin
        if (reset) begin
            regs <= '{default: '0};
        end else begin
            if (we1) regs[waddr1] <= wdata1;
            if (we0) regs[waddr0] <= wdata0;
        end
    end

endmodule

// File: rtl/alu_pipe_datapath.sv
// alu_pipe_datapath: register file + ALU + NZCV flags with a valid/ready issue port
// and an iterative shift-add multiplier.
module alu_pipe_datapath
    import datapath_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [ADDR_WIDTH-1:0] read_reg_num1,
    input  logic [ADDR_WIDTH-1:0] read_reg_num2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [3:0]            alu_control,
    input  logic                  regwrite,
    input  logic                  set_flags,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_reg,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic                  overflow_flag,
    output logic                  negative_flag
);

    localparam int SW = $clog2(DATA_WIDTH);

    state_t                  state;
    logic [3:0]              flags;
    logic [DATA_WIDTH-1:0]   a, b, b_eff, alu_res;
    logic [DATA_WIDTH:0]     sum;
    logic                    sub_op, cin, ovf, arith, upd, op_write, accept;
    logic [SW-1:0]           shamt;
    logic [DATA_WIDTH-1:0]   m_a, m_b, m_acc, m_next;
    logic [SW-1:0]           m_cnt;
    logic [ADDR_WIDTH-1:0]   m_dst;
    logic                    m_wr, m_sf, last;
    logic                    we0;
    logic [ADDR_WIDTH-1:0]   waddr0;
    logic [DATA_WIDTH-1:0]   wdata0;

    assign op_ready      = state == IDLE;
    assign accept        = op_valid && op_ready;
    assign negative_flag = flags[FLAG_N];
    assign zero_flag     = flags[FLAG_Z];
    assign carry_flag    = flags[FLAG_C];
    assign overflow_flag = flags[FLAG_V];

    always_comb begin
        sub_op   = alu_control inside {OP_SUB, OP_SUBS, OP_CMP};
        arith    = alu_control inside {OP_ADD, OP_SUB, OP_ADDS, OP_SUBS, OP_CMP, OP_ADC};
        upd      = (set_flags || alu_control inside {OP_ADDS, OP_SUBS, OP_CMP}) && alu_control != OP_RSVD;
        op_write = regwrite && !(alu_control inside {OP_CMP, OP_RSVD});
        // subtract as A + ~B + 1 so the carry out is NOT borrow
        b_eff    = sub_op ? ~b : b;
        cin      = sub_op ? 1'b1 : (alu_control == OP_ADC ? flags[FLAG_C] : 1'b0);
        sum      = {1'b0, a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, cin};
        ovf      = (a[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
        shamt    = b[SW-1:0];
        alu_res  = '0;
        case (alu_control)
            OP_AND:  alu_res = a & b;
            OP_ORR:  alu_res = a | b;
            OP_EOR:  alu_res = a ^ b;
            OP_MVN:  alu_res = ~a;
            OP_LSL:  alu_res = a << shamt;
            OP_LSR:  alu_res = a >> shamt;
            OP_ASR:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_MOV:  alu_res = b;
            OP_RSVD: alu_res = '0;
            default: alu_res = sum[DATA_WIDTH-1:0];
        endcase
    end

    assign m_next = m_acc + (m_b[0] ? m_a : '0);
    assign last   = state == MUL_BUSY && m_cnt == SW'(DATA_WIDTH - 1);
    assign we0    = (accept && alu_control != OP_MUL && op_write) || (last && m_wr);
    assign waddr0 = op_ready ? write_reg : m_dst;
    assign wdata0 = op_ready ? alu_res : m_next;

    regfile_param #(.DATA_WIDTH(DATA_WIDTH), .REG_COUNT(REG_COUNT)) u_regfile (
        .clock  (clock),
        .reset  (reset),
        .raddr1 (read_reg_num1),
        .raddr2 (read_reg_num2),
        .rdata1 (a),
        .rdata2 (b),
        .we0    (we0),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .we1    (load_en),
        .waddr1 (load_reg),
        .wdata1 (load_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            flags        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            m_a          <= '0;
            m_b          <= '0;
            m_acc        <= '0;
            m_cnt        <= '0;
            m_dst        <= '0;
            m_wr         <= 1'b0;
            m_sf         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (accept && alu_control == OP_MUL) begin
                m_a   <= a;
                m_b   <= b;
                m_acc <= '0;
                m_cnt <= '0;
                m_dst <= write_reg;
                m_wr  <= regwrite;
                m_sf  <= set_flags;
                state <= MUL_BUSY;
            end else if (accept) begin
                result       <= alu_res;
                result_valid <= 1'b1;
                if (upd) begin
                    flags[FLAG_N] <= alu_res[DATA_WIDTH-1];
                    flags[FLAG_Z] <= alu_res == '0;
                    if (arith) begin
                        flags[FLAG_C] <= sum[DATA_WIDTH];
                        flags[FLAG_V] <= ovf;
                    end
                end
            end else if (state == MUL_BUSY) begin
                m_acc <= m_next;
                m_a   <= m_a << 1;
                m_b   <= m_b >> 1;
                m_cnt <= m_cnt + 1'b1;
                if (last) begin
                    state        <= IDLE;
                    result       <= m_next;
                    result_valid <= 1'b1;
                    if (m_sf) begin
                        flags[FLAG_N] <= m_next[DATA_WIDTH-1];
                        flags[FLAG_Z] <= m_next == '0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/alu_pipe_datapath.md
# alu_pipe_datapath

Parametrised successor to the single-cycle DATAPATH block. It combines a `REG_COUNT` × `DATA_WIDTH` register file, an ALU, and an architectural NZCV flag register. It adds a valid/ready issue handshake, a preload write port, carry-in arithmetic, shifts, and an iterative multi-cycle multiply. It sits between instruction decode (issue side) and the condition-check / writeback logic, which consumes `result` and the flags.

## Interface
- `DATA_WIDTH`, 32, operand/register width (≥ 8).
- `REG_COUNT`, 32, number of registers (power of two).
- `ADDR_WIDTH`, $clog2(REG_COUNT), derived; not overridden.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `op_valid`  in  1  operation presented.
- `op_ready`  out  1  block can accept; `op_valid && op_ready` at an edge = accept.
- `read_reg_num1`, `read_reg_num2`  in  ADDR_WIDTH  source registers A, B.
- `write_reg`  in  ADDR_WIDTH  destination register.
- `alu_control`  in  4  opcode.
- `regwrite`  in  1  write result to `write_reg`.
- `set_flags`  in  1  update flags (forced for ADDS/SUBS/CMP).
- `load_en`  in  1  preload write enable.
- `load_reg`  in  ADDR_WIDTH  preload address.
- `load_data`  in  DATA_WIDTH  preload data.
- `result`  out  DATA_WIDTH  last completed result, registered.
- `result_valid`  out  1  one-cycle pulse per completed op.
- `zero_flag`, `carry_flag`, `overflow_flag`, `negative_flag`  out  1  registered Z, C, V, N.

## Operation
- Opcodes:
  - 0000 ADD
  - 0001 SUB
  - 0010 ADDS
  - 0011 SUBS
  - 0100 CMP (A−B, never writes a register)
  - 0101 MUL (low DATA_WIDTH bits of A×B, multi-cycle)
  - 0110 ADC (A+B+C)
  - 0111 AND
  - 1000 ORR
  - 1001 EOR
  - 1010 MVN (~A)
  - 1011 LSL
  - 1100 LSR
  - 1101 ASR (shift A by B[$clog2(DATA_WIDTH)-1:0])
  - 1110 MOV (B)
  - 1111 reserved: no write, no flag update, `result_valid` still pulses with `result` = 0.
- Arithmetic:
  - Computed DATA_WIDTH+1 wide.
  - C = carry out for add. For subtract, C = NOT borrow (A ≥ B unsigned ⇒ C=1).
  - V = signed overflow.
- Flag update:
  - Happens when `set_flags` = 1, or the opcode is ADDS/SUBS/CMP.
  - Arithmetic ops (ADD/SUB/ADDS/SUBS/CMP/ADC) update NZCV.
  - MUL, logical, shift and MOV update N and Z only; C and V hold.
- FSM states: IDLE, MUL_BUSY. `op_ready` = (state == IDLE).
  - IDLE, accept of a non-MUL op: the op completes at that same edge (register write, flags, `result`).
  - IDLE, accept of MUL: latch A, B, destination and control; clear the counter; go to MUL_BUSY.
  - MUL_BUSY: one shift-add step per cycle. After DATA_WIDTH steps, complete and return to IDLE.
  - `op_valid` while busy is ignored.
- Register write priority at an edge:
  - An op completion write beats a preload to the same register.
  - Different registers are written together.
  - Preload is allowed in any state. A preload during MUL_BUSY does not affect the latched operands.
- Operands are read from the register file state before the accept edge. Back-to-back ops see prior writes with no hazard.

## Timing
- Reset values, holding every cycle `reset` is high:
  - all registers 0, NZCV = 0, `result` = 0, `result_valid` = 0, state IDLE.
  - `op_ready` = 1 during and after reset.
- Non-MUL op accepted at edge k: `result`, register write and flags are visible after edge k. `result_valid` is high for the cycle following k.
- MUL accepted at edge k:
  - `op_ready` is low after edge k through edge k+DATA_WIDTH.
  - Completion occurs at edge k+DATA_WIDTH; `result_valid` is high the following cycle.
  - `op_ready` is high again after edge k+DATA_WIDTH; a new op can be accepted at edge k+DATA_WIDTH+1.
- Reset asserted mid-MUL aborts it: no register write, no `result_valid`, all state reset.
- Shift amount 0 passes A through unchanged.
- ASR fills with A[DATA_WIDTH−1].

## Structure
- Shared package `datapath_pkg`:
  - opcode localparams
  - state enum (IDLE, MUL_BUSY)
  - flag bit-index constants
- One sub-module, `regfile_param`:
  - parameters DATA_WIDTH, REG_COUNT
  - two combinational read ports
  - two synchronous write ports, with port 0 (op) having priority over port 1 (preload)
  - synchronous reset to zero
- ALU, flag logic and multiplier FSM live in the top module.

## Test plan
All values assume DATA_WIDTH=32, REG_COUNT=32.
1. Reset, preload r0=5 and r1=3, then ADD r2=r0+r1 → `result` = 8 with a single `result_valid` pulse; r2 = 8; NZCV unchanged at 0000.
2. SUBS r3=r1−r0 → 0xFFFFFFFE, N=1 Z=0 C=0 V=0. Then CMP r0,r0 with `regwrite`=1 → no register write, Z=1 C=1.
3. Preload r4=0x7FFFFFFF, r5=1; ADDS → 0x80000000 with N=1 V=1 C=0. Then r6=0xFFFFFFFF, ADDS r6+r5 → 0 with Z=1 C=1. Then ADC r0+r0 (both 0 after reset of r0? use r7=r8=0) → 1.
4. MUL 7×6, then hold `op_valid` with an ADD during busy:
   - `op_ready` is low exactly 32 cycles and the ADD is not accepted.
   - `result` = 42; N=Z=0; C and V unchanged.
   - The ADD is accepted on the first ready cycle.
5. Preload and op completion hit the same register at the same edge → op value wins. Preload of another register at that edge also lands.
6. Reset asserted 10 cycles into a MUL → `op_ready` = 1, all registers and flags 0, and no `result_valid` pulse.
